// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - fetch stage: PC owner, single-outstanding imem requests, decode handshake
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] pc_plus4
);

  typedef enum logic [1:0] {
    START = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nx;

  logic [31:0] pc;
  logic [31:0] pc_nx;
  logic [31:0] target;
  logic [31:0] target_nx;
  logic        kill;
  logic        kill_nx;
  logic        valid_nx;
  logic [31:0] instr_nx;
  logic [31:0] instr_pc_nx;
  logic [31:0] pc_plus4_nx;

  logic [31:0] redirect_aligned;
  logic [31:0] pc_inc;

  // Low two bits of the redirect target are dropped: fetch is always word-aligned.
  assign redirect_aligned = redirect_pc & ~32'h0000_0003;
  assign pc_inc           = pc + 32'd4;

  // The request is a level held for the whole FETCH state, so the address
  // must not move until the ack arrives; it is simply the PC register.
  assign imem_req  = (state == FETCH);
  assign imem_addr = pc;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= START;
    end else begin
      state <= state_nx;
    end
  end

  // Datapath registers: PC, pending-redirect bookkeeping and the output slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      target      <= RESET_PC;
      kill        <= 1'b0;
      instr_valid <= 1'b0;
      instr       <= 32'h0000_0000;
      instr_pc    <= 32'h0000_0000;
      pc_plus4    <= 32'h0000_0000;
    end else begin
      pc          <= pc_nx;
      target      <= target_nx;
      kill        <= kill_nx;
      instr_valid <= valid_nx;
      instr       <= instr_nx;
      instr_pc    <= instr_pc_nx;
      pc_plus4    <= pc_plus4_nx;
    end
  end

  // Next-state and next-datapath logic; everything holds unless a branch below moves it.
  always_comb begin
    state_nx    = state;
    pc_nx       = pc;
    target_nx   = target;
    kill_nx     = kill;
    valid_nx    = instr_valid;
    instr_nx    = instr;
    instr_pc_nx = instr_pc;
    pc_plus4_nx = pc_plus4;

    case (state)
      START: begin
        state_nx = FETCH;
      end

      FETCH: begin
        if (imem_ack) begin
          if (kill || redirect_valid) begin
            // Wrong-path word: drop it and restart at the newest target.
            pc_nx   = redirect_valid ? redirect_aligned : target;
            kill_nx = 1'b0;
          end else begin
            instr_nx    = imem_rdata;
            instr_pc_nx = pc;
            pc_plus4_nx = pc_inc;
            valid_nx    = 1'b1;
            pc_nx       = pc_inc;
            state_nx    = HOLD;
          end
        end else if (redirect_valid) begin
          // Request in flight: remember where to go, squash the returning word.
          target_nx = redirect_aligned;
          kill_nx   = 1'b1;
        end
      end

      HOLD: begin
        if (redirect_valid) begin
          // Redirect wins over ready; a coincident ready still consumed the word.
          valid_nx = 1'b0;
          pc_nx    = redirect_aligned;
          state_nx = FETCH;
        end else if (instr_ready) begin
          valid_nx = 1'b0;
          state_nx = FETCH;
        end
      end

      default: begin
        state_nx = START;
      end
    endcase
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] pc_plus4;

  logic        rst2_n;
  logic        req2;
  logic [31:0] addr2;
  logic        ack2;
  logic        valid2;
  logic        ready2;
  logic [31:0] instr2;
  logic [31:0] instr_pc2;
  logic [31:0] pc_plus4_2;

  instr_fetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc), .pc_plus4(pc_plus4)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst_n(rst2_n),
    .imem_req(req2), .imem_addr(addr2), .imem_ack(ack2), .imem_rdata(32'h1234_5678),
    .redirect_valid(1'b0), .redirect_pc(32'h0000_0000),
    .instr_valid(valid2), .instr_ready(ready2),
    .instr(instr2), .instr_pc(instr_pc2), .pc_plus4(pc_plus4_2)
  );

  assign ack2 = req2;

  int total = 0;
  int bad   = 0;

  // memory model: ack after 'lat' wait cycles of a held request
  int lat = 0;
  int cnt = 0;
  bit force_bad = 0;
  bit force_ack = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0000_0020;
    return {a[15:0], ~a[15:0]};
  endfunction

  assign imem_ack   = (imem_req && (cnt >= lat)) || force_ack;
  assign imem_rdata = force_bad ? 32'hDEAD_BEEF : mem_word(imem_addr);

  always @(posedge clk) begin
    if (!imem_req || imem_ack) cnt <= 0;
    else cnt <= cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // scoreboard of instructions expected at the decode handshake
  typedef struct {
    logic [31:0] word;
    logic [31:0] pc;
    logic [31:0] pc4;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  bit   seen_bad = 0;

  always begin
    @(negedge clk);
    #2;
    if (rst_n && instr_valid && instr_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_handshake actual instr=%h pc=%h required none", instr, instr_pc);
      end else begin
        mon_e = sb.pop_front();
        chk("sb_instr", instr, mon_e.word);
        chk("sb_instr_pc", instr_pc, mon_e.pc);
        chk("sb_pc_plus4", pc_plus4, mon_e.pc4);
      end
    end
    if (instr_valid && instr == 32'hDEAD_BEEF) seen_bad = 1;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_valid(input logic [31:0] pc, output int reqc, output bit addr_ok);
    reqc = 0;
    addr_ok = 1;
    for (int n = 0; n < 40 && !instr_valid; n++) begin
      if (imem_req) begin
        reqc++;
        if (imem_addr !== pc) addr_ok = 0;
      end
      step();
    end
    chk("valid_seen", {31'b0, instr_valid}, 32'd1);
  endtask

  task automatic pulse_ready();
    instr_ready = 1;
    step();
    instr_ready = 0;
  endtask

  task automatic fetch_one(input logic [31:0] pc, input logic [31:0] word, input int l, input int stall);
    int reqc;
    bit addr_ok;
    bit stable;
    lat = l;
    sb.push_back('{word, pc, pc + 32'd4});
    wait_valid(pc, reqc, addr_ok);
    chk("req_cycles", reqc, l + 1);
    chk("addr_stable", {31'b0, addr_ok}, 32'd1);
    stable = 1;
    for (int s = 0; s < stall; s++) begin
      if (!instr_valid || instr !== word || imem_req) stable = 0;
      step();
    end
    chk("hold_stable", {31'b0, stable}, 32'd1);
    pulse_ready();
  endtask

  typedef struct {
    int          lat;
    int          stall;
    logic [31:0] pc;
    logic [31:0] word;
  } vec_t;
  vec_t vecs[4];

  initial begin
    int  reqc;
    bit  addr_ok;
    bit  path_ok;

    vecs[0] = '{0, 0, 32'h0000_0000, 32'h0000_0020};
    vecs[1] = '{3, 4, 32'h0000_0004, 32'h0004_FFFB};
    vecs[2] = '{1, 2, 32'h0000_0008, 32'h0008_FFF7};
    vecs[3] = '{2, 0, 32'h0000_000C, 32'h000C_FFF3};

    rst_n = 0;
    rst2_n = 0;
    instr_ready = 0;
    ready2 = 0;
    redirect_valid = 0;
    redirect_pc = 0;
    step();
    step();
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chk("rst_pc_plus4", pc_plus4, 32'h0);
    chk("rst2_addr", addr2, 32'hFFFF_FFFC);

    rst_n = 1;
    chk("start_no_req", {31'b0, imem_req}, 32'd0);
    step();
    chk("first_req", {31'b0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, 32'h0);

    for (int i = 0; i < 4; i++) begin
      fetch_one(vecs[i].pc, vecs[i].word, vecs[i].lat, vecs[i].stall);
    end
    chk("next_addr_seq", imem_addr, 32'h0000_0010);

    // redirect while request at 0x10 is outstanding; returning word must be squashed
    lat = 2;
    force_bad = 1;
    redirect_valid = 1;
    redirect_pc = 32'h0000_0103;
    step();
    redirect_valid = 0;
    path_ok = 1;
    for (int n = 0; n < 20 && imem_addr !== 32'h0000_0100; n++) begin
      if (imem_addr !== 32'h0000_0010) path_ok = 0;
      step();
    end
    chk("kill_addr_held", {31'b0, path_ok}, 32'd1);
    chk("redirect_addr", imem_addr, 32'h0000_0100);
    chk("kill_no_valid", {31'b0, instr_valid}, 32'd0);
    force_bad = 0;
    fetch_one(32'h0000_0100, 32'h0100_FEFF, 0, 0);

    // redirect together with ready in HOLD
    lat = 0;
    sb.push_back('{32'h0104_FEFB, 32'h0000_0104, 32'h0000_0108});
    wait_valid(32'h0000_0104, reqc, addr_ok);
    instr_ready = 1;
    redirect_valid = 1;
    redirect_pc = 32'h0000_0040;
    step();
    instr_ready = 0;
    redirect_valid = 0;
    chk("hold_redir_valid", {31'b0, instr_valid}, 32'd0);
    chk("hold_redir_req", {31'b0, imem_req}, 32'd1);
    chk("hold_redir_addr", imem_addr, 32'h0000_0040);
    fetch_one(32'h0000_0040, 32'h0040_FFBF, 1, 1);

    // reset in the middle of a request, released while memory still acks
    lat = 5;
    step();
    step();
    chk("mid_req_pending", {31'b0, imem_req}, 32'd1);
    rst_n = 0;
    force_ack = 1;
    force_bad = 1;
    #1;
    chk("mid_rst_req", {31'b0, imem_req}, 32'd0);
    chk("mid_rst_addr", imem_addr, 32'h0);
    chk("mid_rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("mid_rst_instr", instr, 32'h0);
    step();
    rst_n = 1;
    step();
    chk("after_rst_req", {31'b0, imem_req}, 32'd1);
    chk("after_rst_addr", imem_addr, 32'h0);
    chk("after_rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("after_rst_instr", instr, 32'h0);
    force_ack = 0;
    force_bad = 0;
    fetch_one(32'h0000_0000, 32'h0000_0020, 0, 0);

    // PC wrap from 0xFFFF_FFFC
    rst2_n = 1;
    step();
    chk("wrap_req", {31'b0, req2}, 32'd1);
    chk("wrap_addr", addr2, 32'hFFFF_FFFC);
    step();
    chk("wrap_valid", {31'b0, valid2}, 32'd1);
    chk("wrap_instr", instr2, 32'h1234_5678);
    chk("wrap_instr_pc", instr_pc2, 32'hFFFF_FFFC);
    chk("wrap_pc_plus4", pc_plus4_2, 32'h0);
    ready2 = 1;
    step();
    ready2 = 0;
    chk("wrap_valid_drop", {31'b0, valid2}, 32'd0);
    chk("wrap_next_addr", addr2, 32'h0);
    chk("wrap_next_req", {31'b0, req2}, 32'd1);

    step();
    step();
    chk("sb_empty", sb.size(), 32'd0);
    chk("no_wrong_path", {31'b0, seen_bad}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Fetch stage directly upstream of the MIPS execute datapath; produces the 32-bit instruction word whose fields drive the control unit, sign extender and ALU operand muxes. Owns the program counter and issues one outstanding request at a time to a variable-latency instruction memory. Presents the fetched instruction to decode through a valid/ready handshake. Accepts branch/jump redirects from downstream and discards any wrong-path fetch.

Parameters:
RESET_PC, 32'h0000_0000, PC value fetched first after reset; bits [1:0] must be 0.

Ports:
clk  input  1  single clock, rising-edge.
rst_n  input  1  asynchronous active-low reset.
imem_req  output  1  instruction-memory request, level.
imem_addr  output  32  byte address of request; word-aligned.
imem_ack  input  1  memory returns data this cycle.
imem_rdata  input  32  instruction word, valid when imem_ack=1.
redirect_valid  input  1  branch/jump taken; overrides sequential PC.
redirect_pc  input  32  redirect target; bits [1:0] ignored (forced 00).
instr_valid  output  1  instr/instr_pc/pc_plus4 hold a valid fetched instruction.
instr_ready  input  1  downstream accepts instruction this cycle.
instr  output  32  fetched instruction word ([31:26] opcode, [5:0] funct, etc.).
instr_pc  output  32  address of instr.
pc_plus4  output  32  instr_pc + 4, mod 2^32.

Behaviour:
- Reset (rst_n=0, asynchronous): state=START, pc=RESET_PC, kill=0, imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0, pc_plus4=0.
- States: START, FETCH, HOLD. imem_req=1 only in FETCH; imem_addr=pc always.
- START: one cycle after reset release, unconditionally -> FETCH.
- FETCH: request accepted on the cycle imem_req&&imem_ack (same-cycle ack allowed, i.e. zero-wait memory gives data on the first FETCH cycle). imem_addr is stable while waiting for ack.
  - ack, kill=0, redirect_valid=0: latch instr<=imem_rdata, instr_pc<=pc, pc_plus4<=pc+4, instr_valid<=1, pc<=pc+4, -> HOLD.
  - ack with kill=1 or redirect_valid=1: discard imem_rdata; pc<=(redirect_valid ? {redirect_pc[31:2],2'b00} : saved target); kill<=0; stay FETCH (new request at new address next cycle).
  - no ack, redirect_valid=1: save target, kill<=1; pc/imem_addr unchanged until ack (memory protocol forbids changing address mid-request). A later redirect before ack overwrites the saved target.
- HOLD: outputs stable while instr_valid=1 and instr_ready=0.
  - redirect_valid=1 (priority over ready): instr_valid<=0, pc<=aligned redirect_pc, -> FETCH. If instr_ready was also 1, the handshake still counts as completed (downstream consumed the instruction, e.g. the branch itself).
  - instr_ready=1, no redirect: instr_valid<=0, -> FETCH at pc (already sequential next).
- Throughput: max one instruction per 2 cycles with zero-wait memory (FETCH, HOLD). No prefetch.
- Arithmetic: pc+4 is 32-bit, wraps 0xFFFF_FFFC -> 0x0000_0000, no flag.
- instr, instr_pc, pc_plus4 change only when a non-discarded ack is latched; they retain their value after handshake.
- Reset mid-request: all state cleared immediately; any in-flight ack after reset release is ignored (imem_req=0 in START, ack ignored unless state=FETCH).
- imem_ack while imem_req=0: ignored.

Test Plan:
Reset release, zero-wait memory returning 0x0000_0020 at addr 0, instr_ready=1 -> imem_req high 1 cycle after release at addr 0x0, instr_valid=1 next cycle with instr=0x0000_0020, instr_pc=0, pc_plus4=4; next request addr 0x4.
Memory latency 3 cycles, instr_ready=0 for 4 cycles in HOLD -> imem_addr stable for 3 cycles, instr/instr_valid stable for 4 HOLD cycles, no new imem_req until ready.
redirect_valid with redirect_pc=0x0000_0103 during FETCH wait (ack 2 cycles later, data 0xDEAD_BEEF) -> 0xDEAD_BEEF never appears on instr; next request addr 0x0000_0100.
redirect_valid and instr_ready together in HOLD with redirect_pc=0x40 -> instr_valid drops next cycle, next request addr 0x40, no instruction from pc_plus4 delivered.
RESET_PC=0xFFFF_FFFC, instruction fetched -> pc_plus4=0x0000_0000, next imem_addr=0x0.
rst_n asserted mid-request, then released while memory acks -> outputs at reset values, ack ignored, first request at RESET_PC after START cycle.
